// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests, sequences flushes with PC redirect and fetch bubbles.
// Optional stall watchdog enabled by defining PIPE_CTRL_WDT_EN.
module pipe_ctrl #(
    parameter int FLUSH_BUBBLES = 2,
    parameter int STALL_MAX     = 15,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             flush_req_i,
    input  logic [31:0]      new_pc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH, DRAIN} state_t;

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [2:0]       BUB_LOAD = 3'(FLUSH_BUBBLES);

    state_t           state_reg, state_next;
    logic [2:0]       bub_reg, bub_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      pc_reg;
    logic             flush_reg, busy_reg;
    logic [5:0]       req_vec;
    logic             any_req;

    // EX request also stalls EX/MEM, so it dominates the ID request.
    always_comb begin
        req_vec = 6'b000000;
        if (stallreq_ex_i)
            req_vec = 6'b001111;
        else if (stallreq_id_i)
            req_vec = 6'b000111;
    end
    assign any_req = stallreq_ex_i | stallreq_id_i;

    always_comb begin
        state_next = state_reg;
        bub_next   = bub_reg;
        cnt_next   = cnt_reg;
        if (flush_req_i) begin
            state_next = FLUSH;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                RUN, STALL: begin
                    state_next = any_req ? STALL : RUN;
                    if (!any_req)
                        cnt_next = '0;
                    else if (cnt_reg != CNT_SAT)
                        cnt_next = cnt_reg + 1'b1;
                end
                FLUSH: begin
                    bub_next   = BUB_LOAD;
                    state_next = (FLUSH_BUBBLES > 0) ? DRAIN : RUN;
                end
                DRAIN: begin
                    if (bub_reg <= 3'd1)
                        state_next = any_req ? STALL : RUN;
                    else
                        bub_next = bub_reg - 1'b1;
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            bub_reg   <= 3'd0;
            cnt_reg   <= '0;
            pc_reg    <= 32'd0;
            flush_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            bub_reg   <= bub_next;
            cnt_reg   <= cnt_next;
            flush_reg <= (state_next == FLUSH);
            busy_reg  <= (state_next != RUN);
            if (flush_req_i)
                pc_reg <= new_pc_i;
        end
    end

    // Gated by rst so the combinational stall path also clears during reset.
    always_comb begin
        stall_o = 6'b000000;
        if (!rst) begin
            case (state_reg)
                RUN, STALL: stall_o = req_vec;
                DRAIN:      stall_o = req_vec | 6'b000001;
                default:    stall_o = 6'b000000;
            endcase
        end
    end

    assign flush_o     = flush_reg;
    assign new_pc_o    = pc_reg;
    assign busy_o      = busy_reg;
    assign stall_cnt_o = cnt_reg;

`ifdef PIPE_CTRL_WDT_EN
    // The counter only rises monotonically back from 0, so an edge into STALL_MAX fires once per stall run.
    logic timeout_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_reg <= 1'b0;
        else
            timeout_reg <= (cnt_next == CNT_W'(STALL_MAX)) && (cnt_reg != CNT_W'(STALL_MAX));
    end
    assign timeout_o = timeout_reg;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with hand-computed expectations (FLUSH_BUBBLES=2, STALL_MAX=15, CNT_W=4).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id_i, stallreq_ex_i, flush_req_i;
    logic [31:0] new_pc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;
    logic [3:0]  stall_cnt_o;
    logic        timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(.FLUSH_BUBBLES(2), .STALL_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
        .flush_req_i(flush_req_i), .new_pc_i(new_pc_i),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .busy_o(busy_o), .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"},   32'(stall_o),     32'h0);
        check({tag, ".flush"},   32'(flush_o),     32'h0);
        check({tag, ".pc"},      new_pc_o,         32'h0);
        check({tag, ".busy"},    32'(busy_o),      32'h0);
        check({tag, ".cnt"},     32'(stall_cnt_o), 32'h0);
        check({tag, ".timeout"}, 32'(timeout_o),   32'h0);
    endtask

    initial begin
        logic exp_to;
        rst = 1'b1;
        stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0; flush_req_i = 1'b0; new_pc_i = 32'h0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Decode stall for three cycles
        stallreq_id_i = 1'b1;
        #1;
        check("id0.stall", 32'(stall_o), 32'h07);
        check("id0.busy",  32'(busy_o),  32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 3) stallreq_id_i = 1'b0;
            #1;
            check($sformatf("id%0d.stall", k), 32'(stall_o), (k == 3) ? 32'h00 : 32'h07);
            check($sformatf("id%0d.busy", k),  32'(busy_o),  32'h1);
            check($sformatf("id%0d.cnt", k),   32'(stall_cnt_o), 32'(k));
        end
        tick();
        check("id_end.cnt",  32'(stall_cnt_o), 32'h0);
        check("id_end.busy", 32'(busy_o), 32'h0);

        // Request merging
        stallreq_id_i = 1'b1; stallreq_ex_i = 1'b1; #1;
        check("both.stall", 32'(stall_o), 32'h0f);
        stallreq_id_i = 1'b0; #1;
        check("ex.stall", 32'(stall_o), 32'h0f);
        stallreq_ex_i = 1'b0;
        tick(); tick();

        // Flush from RUN with a simultaneous decode stall
        flush_req_i = 1'b1; new_pc_i = 32'h100; stallreq_id_i = 1'b1; #1;
        check("fl_n.stall", 32'(stall_o), 32'h07);
        tick();
        flush_req_i = 1'b0; stallreq_id_i = 1'b0; new_pc_i = 32'hdead_beef; #1;
        check("fl_n1.flush", 32'(flush_o), 32'h1);
        check("fl_n1.pc",    new_pc_o, 32'h100);
        check("fl_n1.stall", 32'(stall_o), 32'h00);
        check("fl_n1.cnt",   32'(stall_cnt_o), 32'h0);
        tick();
        check("fl_n2.stall", 32'(stall_o), 32'h01);
        check("fl_n2.flush", 32'(flush_o), 32'h0);
        tick();
        check("fl_n3.stall", 32'(stall_o), 32'h01);
        check("fl_n3.busy",  32'(busy_o), 32'h1);
        tick();
        check("fl_n4.stall", 32'(stall_o), 32'h00);
        check("fl_n4.busy",  32'(busy_o), 32'h0);
        check("fl_n4.pc",    new_pc_o, 32'h100);

        // Flush re-entered from the first DRAIN cycle
        flush_req_i = 1'b1; new_pc_i = 32'h100;
        tick();
        flush_req_i = 1'b0;
        tick();
        flush_req_i = 1'b1; new_pc_i = 32'h200; #1;
        check("fd_d1.stall", 32'(stall_o), 32'h01);
        tick();
        flush_req_i = 1'b0; #1;
        check("fd_f.flush", 32'(flush_o), 32'h1);
        check("fd_f.pc",    new_pc_o, 32'h200);
        tick();
        check("fd_d1b.stall", 32'(stall_o), 32'h01);
        tick();
        stallreq_id_i = 1'b1; #1;
        check("fd_d2.stall", 32'(stall_o), 32'h07);
        tick();
        check("fd_exit.stall", 32'(stall_o), 32'h07);
        check("fd_exit.busy",  32'(busy_o), 32'h1);
        check("fd_exit.flush", 32'(flush_o), 32'h0);
        check("fd_exit.cnt",   32'(stall_cnt_o), 32'h0);
        stallreq_id_i = 1'b0;
        tick();
        check("fd_run.busy", 32'(busy_o), 32'h0);

        // Long EX stall: saturation and watchdog
        stallreq_ex_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef PIPE_CTRL_WDT_EN
            exp_to = (k == 15);
`else
            exp_to = 1'b0;
`endif
            check($sformatf("wd%0d.cnt", k),     32'(stall_cnt_o), (k < 15) ? 32'(k) : 32'd15);
            check($sformatf("wd%0d.timeout", k), 32'(timeout_o), 32'(exp_to));
            check($sformatf("wd%0d.stall", k),   32'(stall_o), 32'h0f);
        end
        stallreq_ex_i = 1'b0;
        tick();
        check("wd_end.cnt", 32'(stall_cnt_o), 32'h0);

        // Asynchronous reset mid-DRAIN
        flush_req_i = 1'b1; new_pc_i = 32'h300;
        tick();
        flush_req_i = 1'b0;
        tick();
        stallreq_id_i = 1'b1; #1;
        check("ar_drain.stall", 32'(stall_o), 32'h07);
        check("ar_drain.pc",    new_pc_o, 32'h300);
        rst = 1'b1; #1;
        check_all_zero("ar");
        tick();
        rst = 1'b0; stallreq_id_i = 1'b0;
        tick();
        check("ar_after.busy",  32'(busy_o), 32'h0);
        check("ar_after.stall", 32'(stall_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. Merges stall requests from the decode stage (load-use hazards) and the execute stage (multi-cycle operations) into the per-stage stall vector. Sequences pipeline flushes, including a PC redirect and a configurable number of fetch bubbles. Sits beside the stage registers and drives their stall/flush inputs, plus the PC register's redirect.

## Interface
- FLUSH_BUBBLES, 2: cycles of PC hold inserted after a flush (0 to 7).
- STALL_MAX, 15: consecutive-stall count at which the watchdog fires (1 to 2^CNT_W-1).
- CNT_W, 4: width of the stall counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stallreq_id_i  in  1  decode-stage stall request.
- stallreq_ex_i  in  1  execute-stage stall request.
- flush_req_i  in  1  flush request (exception/redirect).
- new_pc_i  in  32  redirect target, valid with flush_req_i.
- stall_o  out  6  stall vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
- flush_o  out  1  clear all stage registers this cycle.
- new_pc_o  out  32  redirect target for the PC register.
- busy_o  out  1  controller not in RUN.
- stall_cnt_o  out  CNT_W  consecutive stall cycles.
- timeout_o  out  1  watchdog pulse.

## Operation
- States: RUN, STALL, FLUSH, DRAIN. On reset the state is RUN and all outputs are 0.
- Request vector (combinational from inputs):
  - stallreq_ex_i gives 6'b001111.
  - stallreq_id_i only gives 6'b000111.
  - Neither gives 6'b000000.
  - The EX request dominates the ID request.
- RUN/STALL:
  - stall_o = request vector (same cycle, combinational); flush_o = 0.
  - If flush_req_i is sampled at the edge, go to FLUSH and capture new_pc_i into new_pc_o.
  - Otherwise, any request goes to STALL and no request goes to RUN.
- FLUSH: exactly one cycle.
  - flush_o = 1; stall_o = 6'b000000; new_pc_o is stable.
  - Next state is DRAIN if FLUSH_BUBBLES > 0, else RUN.
  - The bubble counter loads FLUSH_BUBBLES.
- DRAIN:
  - stall_o = 6'b000001 | request vector.
  - The bubble counter decrements each cycle; at 1, go to RUN (STALL if a request is present).
- Flush priority:
  - flush_req_i in any state, including FLUSH and DRAIN, recaptures new_pc_i and forces FLUSH next cycle.
  - Flush beats stall requests.
- Stall counter:
  - In RUN/STALL: next = any request ? min(cnt+1, 2^CNT_W-1) : 0.
  - Entering FLUSH clears it; it is frozen in DRAIN.
- new_pc_o holds its last captured value until the next flush; its reset value is 0.
- busy_o = (state != RUN), registered with the state.

## Timing
- Stall response: zero latency. stall_o follows the requests combinationally in RUN/STALL/DRAIN.
- Flush latency: flush_req_i high at edge N gives flush_o = 1 in cycle N+1 only. PC hold covers cycles N+2 to N+1+FLUSH_BUBBLES.
- Simultaneous flush_req_i and stall requests in RUN:
  - The stall vector is honored in the current cycle.
  - FLUSH follows in the next cycle.
- Reset asserted mid-flush or mid-drain:
  - All outputs go to 0 immediately (asynchronous), including new_pc_o.
  - After reset deassert the state is RUN.
- stall_cnt_o saturates and never wraps.

## Configuration
- PIPE_CTRL_WDT_EN defined:
  - timeout_o is high for exactly one cycle, the first cycle in which stall_cnt_o equals STALL_MAX.
  - It does not re-fire until the counter has returned to 0.
  - The stall is not released by the watchdog.
- Undefined: timeout_o is tied to 0 and no comparison logic exists. stall_cnt_o still operates.

## Test plan
- Decode stall: stallreq_id_i high for 3 cycles -> stall_o = 6'b000111 in those same cycles; busy_o = 1 for the 3 following cycles; stall_cnt_o reaches 3, then returns to 0 and stall_o returns to 0.
- Both requests: stallreq_id_i = stallreq_ex_i = 1 -> stall_o = 6'b001111.
- Flush from RUN: flush_req_i = 1 with new_pc_i = 32'h0000_0100 at edge N, FLUSH_BUBBLES = 2 -> flush_o = 1 in cycle N+1 with new_pc_o = 32'h100; stall_o = 6'b000001 in N+2 and N+3; RUN in N+4.
- Flush during DRAIN: a second flush_req_i with new_pc_i = 32'h200 in the first DRAIN cycle -> FLUSH re-entered next cycle, new_pc_o = 32'h200, bubble count restarts at 2.
- Watchdog (PIPE_CTRL_WDT_EN, STALL_MAX = 15, CNT_W = 4): stallreq_ex_i held for 20 cycles -> timeout_o pulses once when stall_cnt_o becomes 15; the counter saturates at 15 and stall_o stays 6'b001111. Without the macro, timeout_o stays 0.
- Async reset: assert rst mid-DRAIN -> stall_o, flush_o, new_pc_o, busy_o, stall_cnt_o and timeout_o go to 0 before the next clock edge.
